candy_mem_responder: RTL and testbench
======================================

CANDY_MEM_RESPONDER -- requirements
Module: candy_mem_responder

Interface
REQ-001 Parameter ADDR_W, default 16, word-address width.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter DEPTH, default 1024, number of storage words.
REQ-004 Parameter WAIT, default 2, wait-state cycles per access, legal range 0..15.
REQ-005 clk  input  1  sole clock, all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 read_enable  input  1  read request from fetch/load initiator.
REQ-008 raddr  input  ADDR_W  read word address.
REQ-009 rdata  output  DATA_W  read data, valid when rdata_ready=1, held until next read completes.
REQ-010 rdata_ready  output  1  one-cycle read-completion pulse.
REQ-011 write_enable  input  1  write request from write-back initiator.
REQ-012 waddr  input  ADDR_W  write word address.
REQ-013 wdata  input  DATA_W  write data.
REQ-014 busy  output  1  high while an access is in flight, requests ignored.
REQ-015 err  output  1  one-cycle out-of-range pulse (see Configuration).

Function
REQ-016 The FSM SHALL have states IDLE, RWAIT, RDONE, WWAIT, WDONE; busy=1 in every state except IDLE.
REQ-017 A request SHALL be accepted only in IDLE; addresses and wdata are registered on the accept edge, and input changes after accept have no effect.
REQ-018 Read accepted at cycle T: RWAIT for WAIT cycles (skipped if WAIT=0), then RDONE at cycle T+WAIT+1 with rdata_ready=1 and rdata updated, then IDLE.
REQ-019 Write accepted at cycle T: WWAIT for WAIT cycles, then WDONE at cycle T+WAIT+1; the storage word is updated at the end of WDONE, then IDLE.
REQ-020 Simultaneous read_enable and write_enable in IDLE: the write SHALL be served first, the read address latched as pending, and WDONE SHALL go to RWAIT (or RDONE if WAIT=0); rdata_ready is asserted at T+2*(WAIT+1).
REQ-021 A pending read to the address just written SHALL return the new wdata.
REQ-022 Requests while busy=1, including a held read_enable during RDONE, SHALL be ignored; the initiator drops read_enable on rdata_ready.
REQ-023 The wait counter SHALL be 4 bits, load WAIT on entry to RWAIT/WWAIT, and decrement to 0 without wrapping.
REQ-024 rdata_ready and err SHALL never be high for two consecutive cycles.

Reset
REQ-025 On rst=1 at a clock edge: state=IDLE, rdata=0, rdata_ready=0, busy=0, err=0, pending-read flag cleared, wait counter=0.
REQ-026 Storage contents SHALL NOT be reset.
REQ-027 Reset during WWAIT SHALL drop the write; reset in WDONE SHALL take priority, so the write is not committed.
REQ-028 Reset during RWAIT/RDONE SHALL cancel the read with no rdata_ready pulse.

Configuration
REQ-029 Macro CANDY_MEM_RANGE_CHECK_EN defined: an address >= DEPTH SHALL complete with normal latency, a read returning rdata=0, a write leaving storage unchanged, and err=1 in the same cycle as RDONE/WDONE.
REQ-030 Macro CANDY_MEM_RANGE_CHECK_EN undefined: the address SHALL be used modulo DEPTH (low bits) and err SHALL be tied to 0.

Verification (WAIT=2, DEPTH=1024)
REQ-031 Write waddr=0x0010, wdata=0xDEADBEEF at T0 -> busy high T0+1..T0+3, idle T0+4; read raddr=0x0010 at T0+4 -> rdata_ready pulse at T0+7 with rdata=0xDEADBEEF.
REQ-032 Simultaneous write 0x0020=0x12345678 and read 0x0020 at T0 -> single rdata_ready at T0+6 with rdata=0x12345678.
REQ-033 read_enable held high continuously from T0 -> rdata_ready pulses at T0+3, T0+7, T0+11, never adjacent.
REQ-034 With range check on: read raddr=0x0400 -> rdata=0 and err=1 at T0+3; write 0x0400 then read 0x0000 -> 0x0000 unchanged. With it off: write 0x0400=0xA5A5A5A5, read 0x0000 -> 0xA5A5A5A5, err never high.
REQ-035 Write 0x0030=0x1 committed, then write 0x0030=0x2 with rst asserted in WDONE -> after reset, read 0x0030 returns 0x1; all outputs 0 on the cycle after reset.
REQ-036 WAIT=0: read accepted at T0 -> rdata_ready at T0+1; back-to-back reads complete every 2 cycles.

Source files
------------

// File: rtl/candy_mem_responder.sv
// Wait-stated word memory serving one read initiator and one write-back initiator.
// Define CANDY_MEM_RANGE_CHECK_EN to turn on out-of-range detection; otherwise addresses wrap modulo DEPTH.
module candy_mem_responder #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int WAIT   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_enable,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_ready,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              err
);
    localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    typedef enum logic [2:0] {IDLE, RWAIT, RDONE, WWAIT, WDONE} state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_raddr;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_pending;
    logic              r_errLast;
    logic [3:0]        r_waitCnt;
    logic [ADDR_W-1:0] w_readAddr;
    logic [IDX_W-1:0]  w_readIdx;
    logic [IDX_W-1:0]  w_wIdx;
    logic [DATA_W-1:0] w_readWord;
    logic              w_readBad;
    logic              w_rBad;
    logic              w_wBad;
    logic              w_enterWait;

    // A zero-wait read reaches RDONE straight from IDLE, before raddr is registered.
    assign w_readAddr = (r_state == IDLE) ? raddr : r_raddr;
    assign w_readIdx  = w_readAddr[IDX_W-1:0];
    assign w_wIdx     = r_waddr[IDX_W-1:0];

`ifdef CANDY_MEM_RANGE_CHECK_EN
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    assign w_readBad = ({1'b0, w_readAddr} >= DEPTH_EXT);
    assign w_rBad    = ({1'b0, r_raddr} >= DEPTH_EXT);
    assign w_wBad    = ({1'b0, r_waddr} >= DEPTH_EXT);
`else
    logic w_unused;
    assign w_unused  = ^{r_raddr, r_waddr, w_readAddr};
    assign w_readBad = 1'b0;
    assign w_rBad    = 1'b0;
    assign w_wBad    = 1'b0;
`endif

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (write_enable) begin
                    if (WAIT == 0) w_nextState = WDONE;
                    else           w_nextState = WWAIT;
                end else if (read_enable) begin
                    if (WAIT == 0) w_nextState = RDONE;
                    else           w_nextState = RWAIT;
                end
            end
            RWAIT:   if (r_waitCnt <= 4'd1) w_nextState = RDONE;
            RDONE:   w_nextState = IDLE;
            WWAIT:   if (r_waitCnt <= 4'd1) w_nextState = WDONE;
            WDONE: begin
                if (!r_pending)     w_nextState = IDLE;
                else if (WAIT == 0) w_nextState = RDONE;
                else                w_nextState = RWAIT;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // A pending read leaving WDONE must see the word that commits on that same edge.
    always_comb begin
        w_readWord = r_mem[w_readIdx];
        if (w_readBad)
            w_readWord = '0;
        else if (r_state == WDONE && !w_wBad && w_wIdx == w_readIdx)
            w_readWord = r_wdata;
    end

    assign w_enterWait = (w_nextState == RWAIT || w_nextState == WWAIT) && (w_nextState != r_state);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pending <= 1'b0;
            r_waitCnt <= 4'd0;
            r_rdata   <= '0;
            r_errLast <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_errLast <= err;
            if (r_state == IDLE) begin
                if (write_enable) begin
                    r_waddr   <= waddr;
                    r_wdata   <= wdata;
                    r_pending <= read_enable;
                end
                if (read_enable)
                    r_raddr <= raddr;
            end else if (r_state == WDONE) begin
                r_pending <= 1'b0;
            end
            if (w_enterWait)
                r_waitCnt <= WAIT_CNT;
            else if (r_waitCnt != 4'd0)
                r_waitCnt <= r_waitCnt - 4'd1;
            if (w_nextState == RDONE)
                r_rdata <= w_readWord;
        end
    end

    // Storage is deliberately left out of reset; a reset in WDONE must not commit.
    always_ff @(posedge clk) begin
        if (!rst && r_state == WDONE && !w_wBad)
            r_mem[w_wIdx] <= r_wdata;
    end

    assign busy        = (r_state != IDLE);
    assign rdata_ready = (r_state == RDONE);
    assign rdata       = r_rdata;
    // A pending read right after an erroring write would otherwise pulse err twice in a row.
    assign err         = ((r_state == RDONE) && w_rBad && !r_errLast) ||
                         ((r_state == WDONE) && w_wBad);

endmodule

// File: tb/tb_candy_mem_responder.sv
// Directed self-checking bench: a WAIT=2 responder for the main scenarios and a WAIT=0 one for zero-latency paths.
module tb_candy_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        readEn, writeEn, readEn0, writeEn0;
    logic [15:0] rAddr, wAddr, rAddr0, wAddr0;
    logic [31:0] wData, wData0;
    logic [31:0] rData, rData0;
    logic        rdy, busy, err, rdy0, busy0, err0;
    int          testCount = 0;
    int          failCount = 0;

`ifdef CANDY_MEM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    always #5 clk = ~clk;

    candy_mem_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH(1024), .WAIT(2)) dut (
        .clk(clk), .rst(rst),
        .read_enable(readEn), .raddr(rAddr), .rdata(rData), .rdata_ready(rdy),
        .write_enable(writeEn), .waddr(wAddr), .wdata(wData),
        .busy(busy), .err(err)
    );

    candy_mem_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH(1024), .WAIT(0)) dutWait0 (
        .clk(clk), .rst(rst),
        .read_enable(readEn0), .raddr(rAddr0), .rdata(rData0), .rdata_ready(rdy0),
        .write_enable(writeEn0), .waddr(wAddr0), .wdata(wData0),
        .busy(busy0), .err(err0)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expected);
        testCount++;
        if (got !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic [15:0] ra, input logic w,
                                 input logic [15:0] wa, input logic [31:0] wd);
        readEn  = r;
        rAddr   = ra;
        writeEn = w;
        wAddr   = wa;
        wData   = wd;
    endtask

    // Write accepted at k=0: WWAIT k=1,2, WDONE k=3, IDLE k=4.
    task automatic doWrite(input logic [15:0] a, input logic [31:0] d, input bit expErr);
        applyStimulus(1'b0, 16'h0, 1'b1, a, d);
        tick();
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            checkOutput("wr_busy", 64'(busy), 64'(1));
            checkOutput("wr_err", 64'(err), 64'(k == 3 && expErr));
            tick();
        end
        checkOutput("wr_idle", 64'(busy), 64'(0));
    endtask

    // Read accepted at k=0: RDONE with pulse at k=3, IDLE k=4.
    task automatic doRead(input logic [15:0] a, input logic [31:0] expData, input bit expErr);
        applyStimulus(1'b1, a, 1'b0, 16'h0, 32'h0);
        tick();
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            checkOutput("rd_ready", 64'(rdy), 64'(k == 3));
            checkOutput("rd_err", 64'(err), 64'(k == 3 && expErr));
            if (k == 3) checkOutput("rd_data", 64'(rData), 64'(expData));
            tick();
        end
        checkOutput("rd_idle", 64'(busy), 64'(0));
        checkOutput("rd_pulse_end", 64'(rdy), 64'(0));
    endtask

    initial begin
        readEn0 = 1'b0; writeEn0 = 1'b0; rAddr0 = 16'h0; wAddr0 = 16'h0; wData0 = 32'h0;
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 32'h0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset_rdata", 64'(rData), 64'(0));
        checkOutput("reset_ready", 64'(rdy), 64'(0));
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_err", 64'(err), 64'(0));
        checkOutput("reset_busy0", 64'(busy0), 64'(0));

        // Write then read back; requests held during busy must be ignored.
        applyStimulus(1'b0, 16'h0, 1'b1, 16'h0010, 32'hDEADBEEF);
        tick();
        applyStimulus(1'b1, 16'h0020, 1'b1, 16'h0010, 32'hBAD0BAD0);
        for (int k = 1; k <= 3; k++) begin
            checkOutput("w31_busy", 64'(busy), 64'(1));
            checkOutput("w31_ready", 64'(rdy), 64'(0));
            tick();
        end
        checkOutput("w31_idle", 64'(busy), 64'(0));
        applyStimulus(1'b1, 16'h0010, 1'b0, 16'h0, 32'h0);
        tick();
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 32'h0);
        for (int k = 5; k <= 8; k++) begin
            checkOutput("r31_ready", 64'(rdy), 64'(k == 7));
            if (k >= 7) checkOutput("r31_data", 64'(rData), 64'(32'hDEADBEEF));
            tick();
        end

        // Simultaneous write and read of the same address: write first, one pulse at k=6.
        applyStimulus(1'b1, 16'h0020, 1'b1, 16'h0020, 32'h12345678);
        tick();
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            checkOutput("sim_ready", 64'(rdy), 64'(k == 6));
            checkOutput("sim_busy", 64'(busy), 64'(k <= 6));
            if (k == 6) checkOutput("sim_data", 64'(rData), 64'(32'h12345678));
            if (k < 8) tick();
        end

        // Held read_enable: pulses at k=3,7,11 only.
        applyStimulus(1'b1, 16'h0010, 1'b0, 16'h0, 32'h0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            checkOutput("held_ready", 64'(rdy), 64'(k == 3 || k == 7 || k == 11));
            if (k == 3) checkOutput("held_data", 64'(rData), 64'(32'hDEADBEEF));
        end
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 32'h0);
        tick();
        checkOutput("held_idle", 64'(busy), 64'(0));

        // Address 0x0400 is one past the end: aliases word 0 or flags err.
        doWrite(16'h0000, 32'h11111111, 1'b0);
        doWrite(16'h0400, 32'hA5A5A5A5, RC);
        doRead(16'h0000, RC ? 32'h11111111 : 32'hA5A5A5A5, 1'b0);
        doRead(16'h0400, RC ? 32'h00000000 : 32'hA5A5A5A5, RC);

        // Reset in WDONE must not commit the second write.
        doWrite(16'h0030, 32'h00000001, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b1, 16'h0030, 32'h00000002);
        tick();
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 32'h0);
        tick();
        tick();
        checkOutput("wdone_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst_rdata", 64'(rData), 64'(0));
        checkOutput("rst_ready", 64'(rdy), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_err", 64'(err), 64'(0));
        doRead(16'h0030, 32'h00000001, 1'b0);

        // Reset in RWAIT cancels the read without a pulse.
        applyStimulus(1'b1, 16'h0030, 1'b0, 16'h0, 32'h0);
        tick();
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkOutput("cancel_ready", 64'(rdy), 64'(0));
            checkOutput("cancel_busy", 64'(busy), 64'(0));
            tick();
        end

        // Zero wait states: write completes in one cycle, held reads pulse every other cycle.
        writeEn0 = 1'b1; wAddr0 = 16'h0005; wData0 = 32'hCAFEF00D;
        tick();
        writeEn0 = 1'b0; wData0 = 32'h0;
        checkOutput("w0_busy", 64'(busy0), 64'(1));
        checkOutput("w0_ready", 64'(rdy0), 64'(0));
        tick();
        checkOutput("w0_idle", 64'(busy0), 64'(0));
        readEn0 = 1'b1; rAddr0 = 16'h0005;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checkOutput("r0_ready", 64'(rdy0), 64'(k % 2 == 1));
            if (k % 2 == 1) checkOutput("r0_data", 64'(rData0), 64'(32'hCAFEF00D));
        end
        readEn0 = 1'b0;
        tick();
        checkOutput("r0_idle", 64'(busy0), 64'(0));

        // Zero-wait simultaneous access: the read leaves WDONE on the commit edge.
        writeEn0 = 1'b1; wAddr0 = 16'h0007; wData0 = 32'h0BADC0DE;
        readEn0 = 1'b1; rAddr0 = 16'h0007;
        tick();
        writeEn0 = 1'b0; readEn0 = 1'b0; wData0 = 32'h0;
        checkOutput("s0_wdone", 64'(rdy0), 64'(0));
        tick();
        checkOutput("s0_ready", 64'(rdy0), 64'(1));
        checkOutput("s0_data", 64'(rData0), 64'(32'h0BADC0DE));
        checkOutput("s0_err", 64'(err0), 64'(0));
        tick();
        checkOutput("s0_done", 64'(rdy0), 64'(0));
        checkOutput("s0_idle", 64'(busy0), 64'(0));

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
